// File: rtl/feeder_pkg.sv
// Shared types and burst geometry for the convolution stream feeder.
package feeder_pkg;

    typedef enum logic [1:0] {IDLE, FILL, OFFER, STREAM} state_t;
    typedef enum logic [1:0] {KERNEL, PRELOAD, PIXEL} burst_t;

    localparam int KERNEL_LEN     = 12;
    localparam int PATCH_LEN      = 4;
    localparam int BUF_DEPTH      = 12;
    localparam int PTR_W          = 4;
    localparam int GROUP_SIZE     = 6;
    localparam int PRELOAD_BURSTS = 3;

    function automatic logic [PTR_W-1:0] burst_len(input burst_t kind);
        return (kind == KERNEL) ? PTR_W'(KERNEL_LEN) : PTR_W'(PATCH_LEN);
    endfunction

endpackage

// File: rtl/burst_buffer.sv
// Holds one complete burst so it can be streamed without gaps once offered.
module burst_buffer
    import feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [PTR_W-1:0]      rd_ptr
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;

    always_ff @(posedge clk) begin
        if (rst_in || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (rd_en)
                rd_ptr <= (rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/conv_stream_feeder.sv
// Streams kernel, preload and pixel bursts of a conv layer from linear memory.
module conv_stream_feeder
    import feeder_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 20,
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int OUTPUT_NB_CHANNELS = 32
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  start,
    output logic                  running,
    output logic                  done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  con_valid,
    input  logic                  con_ready,
    output logic [DATA_WIDTH-1:0] con_data,
    output logic                  con_last
);

    localparam int NB_GROUPS   = (OUTPUT_NB_CHANNELS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int LAST_GROUP_K = (OUTPUT_NB_CHANNELS % GROUP_SIZE == 0) ? GROUP_SIZE
                                                                         : OUTPUT_NB_CHANNELS % GROUP_SIZE;
    localparam int X_W = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int Y_W = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int G_W = (NB_GROUPS          > 1) ? $clog2(NB_GROUPS)          : 1;

    state_t                state, state_nxt;
    burst_t                kind;
    logic [2:0]            kern_cnt, group_kernels;
    logic [1:0]            pre_cnt;
    logic [X_W-1:0]        x_cnt;
    logic [Y_W-1:0]        y_cnt;
    logic [G_W-1:0]        grp_cnt;
    logic [PTR_W-1:0]      fill_cnt, rd_ptr, cur_len;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] buf_rdata;
    logic                  vld_p1, done_q;
    logic                  buf_clr, rd_en, burst_end;
    logic                  x_last, y_last, g_last, final_burst;

    assign cur_len       = burst_len(kind);
    assign g_last        = (grp_cnt == G_W'(NB_GROUPS - 1));
    assign x_last        = (x_cnt == X_W'(FEATURE_MAP_WIDTH - 1));
    assign y_last        = (y_cnt == Y_W'(FEATURE_MAP_HEIGHT - 1));
    assign group_kernels = g_last ? 3'(LAST_GROUP_K) : 3'(GROUP_SIZE);
    assign final_burst   = (kind == PIXEL) && x_last && y_last && g_last;

    always_ff @(posedge clk) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        con_valid = 1'b0;
        con_last  = 1'b0;
        rd_en     = 1'b0;
        buf_clr   = 1'b0;
        burst_end = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                    buf_clr   = 1'b1;
                end
            end
            FILL: begin
                mem_re = (fill_cnt < cur_len);
                if (fill_cnt == cur_len)
                    state_nxt = OFFER;
            end
            OFFER: begin
                con_valid = 1'b1;
                if (con_ready) begin
                    rd_en     = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                con_valid = 1'b1;
                rd_en     = 1'b1;
                if (rd_ptr == cur_len - PTR_W'(1)) begin
                    con_last  = 1'b1;
                    burst_end = 1'b1;
                    buf_clr   = 1'b1;
                    state_nxt = final_burst ? IDLE : FILL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: memory data returns one cycle after mem_re and is written here
    always_ff @(posedge clk) begin
        if (rst_in) begin
            vld_p1   <= 1'b0;
            done_q   <= 1'b0;
            fill_cnt <= '0;
            addr     <= '0;
            kind     <= KERNEL;
            kern_cnt <= '0;
            pre_cnt  <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            grp_cnt  <= '0;
        end else begin
            vld_p1   <= mem_re;
            done_q   <= burst_end && final_burst;
            fill_cnt <= (state == FILL) ? fill_cnt + PTR_W'(1) : '0;
            if (state == IDLE && start) begin
                addr     <= '0;
                kind     <= KERNEL;
                kern_cnt <= '0;
                pre_cnt  <= '0;
                x_cnt    <= '0;
                y_cnt    <= '0;
                grp_cnt  <= '0;
            end else begin
                if (mem_re)
                    addr <= addr + ADDR_WIDTH'(1);
                if (burst_end) begin
                    case (kind)
                        KERNEL: begin
                            if (kern_cnt == group_kernels - 3'd1) begin
                                kern_cnt <= '0;
                                kind     <= PRELOAD;
                            end else begin
                                kern_cnt <= kern_cnt + 3'd1;
                            end
                        end
                        PRELOAD: begin
                            if (pre_cnt == 2'(PRELOAD_BURSTS - 1)) begin
                                pre_cnt <= '0;
                                kind    <= PIXEL;
                            end else begin
                                pre_cnt <= pre_cnt + 2'd1;
                            end
                        end
                        default: begin
                            if (!x_last) begin
                                x_cnt <= x_cnt + X_W'(1);
                            end else begin
                                x_cnt <= '0;
                                if (!y_last) begin
                                    y_cnt <= y_cnt + Y_W'(1);
                                    kind  <= PRELOAD;
                                end else begin
                                    y_cnt   <= '0;
                                    kind    <= KERNEL;
                                    grp_cnt <= g_last ? '0 : grp_cnt + G_W'(1);
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    burst_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_in  (rst_in),
        .clr     (buf_clr),
        .wr_en   (vld_p1),
        .wr_data (mem_rdata),
        .rd_en   (rd_en),
        .rd_data (buf_rdata),
        .rd_ptr  (rd_ptr)
    );

    assign running  = (state != IDLE);
    assign done     = done_q;
    assign mem_addr = addr;
    assign con_data = con_valid ? buf_rdata : '0;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Bench for conv_stream_feeder: table-driven layer runs plus abort and 12-channel cases.
module tb_conv_stream_feeder;

    localparam int DW = 16;
    localparam int AW = 20;
    localparam int FMW = 2;
    localparam int FMH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_in, start, start12, con_ready, con_ready12;
    logic          running, done, mem_re, con_valid, con_last;
    logic          running12, done12, mem_re12, con_valid12, con_last12;
    logic [AW-1:0] mem_addr, mem_addr12;
    logic [DW-1:0] mem_rdata, mem_rdata12, con_data, con_data12;

    conv_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(FMW),
                         .FEATURE_MAP_HEIGHT(FMH), .OUTPUT_NB_CHANNELS(8)) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .running(running), .done(done),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data), .con_last(con_last));

    conv_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(FMW),
                         .FEATURE_MAP_HEIGHT(FMH), .OUTPUT_NB_CHANNELS(12)) dut12 (
        .clk(clk), .rst_in(rst_in), .start(start12), .running(running12), .done(done12),
        .mem_re(mem_re12), .mem_addr(mem_addr12), .mem_rdata(mem_rdata12),
        .con_valid(con_valid12), .con_ready(con_ready12), .con_data(con_data12), .con_last(con_last12));

    // Memory word equals its address, one cycle read latency
    always @(posedge clk) begin
        if (mem_re)   mem_rdata   <= DW'(mem_addr);
        if (mem_re12) mem_rdata12 <= DW'(mem_addr12);
    end

    int tot = 0;
    int bad = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        tot++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Expected burst lengths derived directly from the layer traversal order
    function automatic void model_lens(input int oc, input int w, input int h, output int q[$]);
        int ng, nk;
        q  = {};
        ng = (oc + 5) / 6;
        for (int g = 0; g < ng; g++) begin
            nk = (g == ng - 1 && oc % 6 != 0) ? oc % 6 : 6;
            for (int k = 0; k < nk; k++) q.push_back(12);
            for (int y = 0; y < h; y++) begin
                for (int p = 0; p < 3; p++) q.push_back(4);
                for (int x = 0; x < w; x++) q.push_back(4);
            end
        end
    endfunction

    function automatic int qsum(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    typedef struct {
        int in_burst; int words; int bursts; int cur_len;
        int holds; int dones; int raddr; int kbursts;
    } mon_t;

    mon_t ma, mb;
    int   lens_a[$], lens_b[$];
    bit   mon_rst = 1'b1;

    task automatic mon_step(input string tag, input logic v, input logic r, input logic l,
                            input logic dn, input logic run, input logic re,
                            input logic [DW-1:0] d, input logic [AW-1:0] a,
                            input int lens[$], inout mon_t m);
        bit exp_last;
        if (re) begin
            chk({tag, "_rd_addr"}, a, m.raddr);
            chk({tag, "_re_while_valid"}, v, 0);
            m.raddr++;
        end
        if (dn) begin
            m.dones++;
            chk({tag, "_running_at_done"}, run, 0);
        end
        if (v) begin
            if (m.in_burst == 0 && !r) begin
                chk({tag, "_offer_hold_data"}, d, m.words % 65536);
                m.holds++;
            end else begin
                exp_last = (m.bursts < lens.size()) && (m.cur_len + 1 == lens[m.bursts]);
                chk({tag, "_data"}, d, m.words % 65536);
                chk({tag, "_last"}, l, exp_last);
                m.words++;
                m.cur_len++;
                m.in_burst = 1;
                if (l) begin
                    if (m.cur_len == 12) m.kbursts++;
                    m.bursts++;
                    m.cur_len  = 0;
                    m.in_burst = 0;
                end
            end
        end else if (m.in_burst != 0) begin
            chk({tag, "_valid_gap"}, v, 1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_rst) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            mon_step("a", con_valid, con_ready, con_last, done, running, mem_re,
                     con_data, mem_addr, lens_a, ma);
            mon_step("b", con_valid12, con_ready12, con_last12, done12, running12, mem_re12,
                     con_data12, mem_addr12, lens_b, mb);
        end
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = hold low for the first 5 offered cycles
    int rdy_mode = 0;
    int hold_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: con_ready = 1'($urandom_range(0, 1));
            2: begin
                if (con_valid && hold_cnt < 5) begin
                    con_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    con_ready = 1'b1;
                end
            end
            default: con_ready = 1'b1;
        endcase
        if (rdy_mode != 2) hold_cnt = 0;
    end

    task automatic clear_mon();
        mon_rst = 1'b1;
        @(negedge clk);
        #1 mon_rst = 1'b0;
    endtask

    task automatic run_layer(input int mode, input bit restart, output int seen_done);
        rdy_mode = mode;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("running_after_start", running, 1);
        chk("first_addr", mem_addr, 0);
        seen_done = 0;
        for (int cyc = 0; cyc < 5000 && seen_done == 0; cyc++) begin
            if (restart && cyc == 60) begin
                @(posedge clk); #2 start = 1'b1;
                @(posedge clk); #2 start = 1'b0;
            end
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("done_seen", seen_done, 1);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int mode; bit restart; int exp_words; int exp_bursts; int exp_dones; int exp_holds;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int   wa, na, sd, hit;

        model_lens(8, FMW, FMH, lens_a);
        model_lens(12, FMW, FMH, lens_b);
        wa = qsum(lens_a);
        na = lens_a.size();
        tbl[0] = '{0, 1'b0, wa, na, 1, 0};
        tbl[1] = '{1, 1'b0, wa, na, 1, -1};
        tbl[2] = '{1, 1'b1, wa, na, 1, -1};
        tbl[3] = '{2, 1'b0, wa, na, 1, 5};

        rst_in = 1'b1; start = 1'b0; start12 = 1'b0; con_ready12 = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_in = 1'b0;
        @(negedge clk);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_con_valid", con_valid, 0);
        chk("rst_con_last", con_last, 0);
        chk("rst_con_data", con_data, 0);

        foreach (tbl[i]) begin
            clear_mon();
            run_layer(tbl[i].mode, tbl[i].restart, sd);
            chk($sformatf("v%0d_words", i), ma.words, tbl[i].exp_words);
            chk($sformatf("v%0d_last_count", i), ma.bursts, tbl[i].exp_bursts);
            chk($sformatf("v%0d_dones", i), ma.dones, tbl[i].exp_dones);
            chk($sformatf("v%0d_idle_end", i), ma.in_burst, 0);
            if (tbl[i].exp_holds >= 0)
                chk($sformatf("v%0d_hold_cycles", i), ma.holds, tbl[i].exp_holds);
        end

        // Abort during word 7 of the first kernel burst, then replay
        rdy_mode = 0;
        clear_mon();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        hit = 0;
        for (int cyc = 0; cyc < 200 && hit == 0; cyc++) begin
            @(negedge clk);
            if (con_valid && con_data == DW'(7)) hit = 1;
        end
        chk("abort_reach_word7", hit, 1);
        rst_in  = 1'b1;
        mon_rst = 1'b1;
        @(posedge clk);
        #1 rst_in = 1'b0;
        chk("abort_con_valid", con_valid, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_running", running, 0);
        @(negedge clk);
        #1 mon_rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_words", ma.words, 0);
        chk("abort_no_done", ma.dones, 0);
        run_layer(0, 1'b0, sd);
        chk("replay_words", ma.words, wa);
        chk("replay_last_count", ma.bursts, na);
        chk("replay_dones", ma.dones, 1);

        // Twelve output channels: two full kernel groups
        clear_mon();
        @(posedge clk); #2 start12 = 1'b1;
        @(posedge clk); #2 start12 = 1'b0;
        sd = 0;
        for (int cyc = 0; cyc < 5000 && sd == 0; cyc++) begin
            @(negedge clk);
            if (done12) sd = 1;
        end
        chk("oc12_done_seen", sd, 1);
        repeat (3) @(negedge clk);
        chk("oc12_words", mb.words, qsum(lens_b));
        chk("oc12_last_count", mb.bursts, lens_b.size());
        chk("oc12_kernel_bursts", mb.kbursts, 12);
        chk("oc12_dones", mb.dones, 1);
        chk("oc12_other_idle", ma.words, 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", tot, bad);
        $fatal(1, "watchdog");
    end

endmodule
